// File: rtl/ber_accum.sv
// Bit-error-rate accumulator: counts bits, bit errors and words over a
// window of upstream comparator results, with sticky sync-loss and
// invalid-input flags.
module ber_accum #(
    parameter int unsigned WORD_BITS   = 13,
    parameter int unsigned LOSS_THRESH = 7,
    parameter int unsigned LOSS_RUN    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] window_len,
    input  logic        word_valid,
    input  logic [3:0]  err_count,
    output logic        busy,
    output logic        done,
    output logic [19:0] total_bits,
    output logic [19:0] total_errors,
    output logic [16:0] words_seen,
    output logic        sync_lost,
    output logic        err_invalid
);

    localparam int unsigned RUN_W = $clog2(LOSS_RUN + 1);
    localparam logic [3:0]       MAX_ERR = 4'(WORD_BITS);
    localparam logic [3:0]       THRESH  = 4'(LOSS_THRESH);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOSS_RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [16:0]      len_q, len_next;
    logic [RUN_W-1:0] run_q, run_next;
    logic [19:0]      bits_next, errs_next;
    logic [16:0]      words_next;
    logic             sync_next, inv_next;
    logic             busy_next, done_next;
    logic [3:0]       err_clamp;
    logic             err_bad;

    // Clamp out-of-range comparator results to a full-word error
    always_comb begin
        err_bad   = (err_count > MAX_ERR);
        err_clamp = err_bad ? MAX_ERR : err_count;
    end

    // Next-state and next-value logic
    always_comb begin
        state_next = state;
        len_next   = len_q;
        run_next   = run_q;
        bits_next  = total_bits;
        errs_next  = total_errors;
        words_next = words_seen;
        sync_next  = sync_lost;
        inv_next   = err_invalid;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    bits_next  = '0;
                    errs_next  = '0;
                    words_next = '0;
                    sync_next  = 1'b0;
                    inv_next   = 1'b0;
                    run_next   = '0;
                    len_next   = (window_len == 16'd0) ? 17'd65536 : {1'b0, window_len};
                    state_next = RUN;
                end
            end
            RUN: begin
                // abort wins over any word or completion in the same cycle
                if (abort) begin
                    state_next = IDLE;
                end else if (word_valid) begin
                    bits_next  = total_bits + 20'(WORD_BITS);
                    errs_next  = total_errors + 20'(err_clamp);
                    words_next = words_seen + 17'd1;
                    inv_next   = err_invalid | err_bad;
                    if (err_clamp >= THRESH) begin
                        run_next = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
                    end else begin
                        run_next = '0;
                    end
                    if (run_next == RUN_MAX) begin
                        sync_next = 1'b1;
                    end
                    if (words_next == len_q) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            run_q        <= '0;
            total_bits   <= '0;
            total_errors <= '0;
            words_seen   <= '0;
            sync_lost    <= 1'b0;
            err_invalid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            len_q        <= len_next;
            run_q        <= run_next;
            total_bits   <= bits_next;
            total_errors <= errs_next;
            words_seen   <= words_next;
            sync_lost    <= sync_next;
            err_invalid  <= inv_next;
            busy         <= busy_next;
            done         <= done_next;
        end
    end

endmodule

// File: tb/tb_ber_accum.sv
// Directed bench for ber_accum with a window-result scoreboard.
module tb_ber_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] window_len;
    logic        word_valid;
    logic [3:0]  err_count;
    logic        busy;
    logic        done;
    logic [19:0] total_bits;
    logic [19:0] total_errors;
    logic [16:0] words_seen;
    logic        sync_lost;
    logic        err_invalid;

    ber_accum dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .window_len   (window_len),
        .word_valid   (word_valid),
        .err_count    (err_count),
        .busy         (busy),
        .done         (done),
        .total_bits   (total_bits),
        .total_errors (total_errors),
        .words_seen   (words_seen),
        .sync_lost    (sync_lost),
        .err_invalid  (err_invalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] bits;
        logic [19:0] errs;
        logic [16:0] words;
        logic        sync;
        logic        inv;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    int checks = 0;
    int errors = 0;

    // Reference model of the current window
    int m_bits, m_errs, m_words, m_run;
    bit m_sync, m_inv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_bits = 0; m_errs = 0; m_words = 0; m_run = 0;
        m_sync = 1'b0; m_inv = 1'b0;
    endtask

    task automatic model_word(input int e);
        int c;
        c = (e > 13) ? 13 : e;
        if (e > 13) m_inv = 1'b1;
        m_bits  += 13;
        m_errs  += c;
        m_words += 1;
        if (c >= 7) m_run = (m_run >= 4) ? 4 : m_run + 1;
        else        m_run = 0;
        if (m_run == 4) m_sync = 1'b1;
    endtask

    task automatic do_start(input logic [15:0] len);
        window_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic drive_word(input logic [3:0] e);
        word_valid = 1'b1;
        err_count  = e;
        tick();
        word_valid = 1'b0;
        model_word(int'(e));
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.bits  = 20'(m_bits);
        e.errs  = 20'(m_errs);
        e.words = 17'(m_words);
        e.sync  = m_sync;
        e.inv   = m_inv;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    // Wait (bounded) for the window to finish, then check it against the scoreboard
    task automatic wait_done();
        int   n;
        exp_t e;
        string t;
        n = 0;
        word_valid = 1'b0;
        while (done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            chk({t, "_bits"},  32'(total_bits),   32'(e.bits));
            chk({t, "_errs"},  32'(total_errors), 32'(e.errs));
            chk({t, "_words"}, 32'(words_seen),   32'(e.words));
            chk({t, "_sync"},  32'(sync_lost),    32'(e.sync));
            chk({t, "_inv"},   32'(err_invalid),  32'(e.inv));
            chk({t, "_busy"},  32'(busy),         32'd0);
        end
    endtask

    initial begin
        logic [3:0] pat [10];
        pat = '{4'd7, 4'd8, 4'd13, 4'd0, 4'd7, 4'd7, 4'd7, 4'd9, 4'd0, 4'd0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; window_len = '0;
        word_valid = 1'b0; err_count = '0;
        model_clear();
        tick(); tick();
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_bits",  32'(total_bits), 0);
        chk("rst_errs",  32'(total_errors), 0);
        chk("rst_words", 32'(words_seen), 0);
        chk("rst_sync",  32'(sync_lost), 0);
        chk("rst_inv",   32'(err_invalid), 0);
        rst = 1'b0;
        tick();

        // Basic window: 0,1,2,3 -> 52 bits, 6 errors
        do_start(16'd4);
        chk("basic_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) drive_word(4'(i));
        push_exp("basic");
        chk("basic_errs_const", 32'(total_errors), 32'd6);
        wait_done();
        chk("basic_done", 32'(done), 1);

        // start + word in same cycle not counted; clamp; start in RUN ignored
        window_len = 16'd3; start = 1'b1; word_valid = 1'b1; err_count = 4'd15;
        tick();
        start = 1'b0; word_valid = 1'b0;
        model_clear();
        chk("startword_words", 32'(words_seen), 0);
        chk("startword_busy", 32'(busy), 1);
        drive_word(4'd15);
        chk("clamp_errs", 32'(total_errors), 32'd13);
        chk("clamp_inv", 32'(err_invalid), 1);
        start = 1'b1; window_len = 16'd9;
        drive_word(4'd2);
        start = 1'b0;
        chk("run_start_words", 32'(words_seen), 32'd2);
        drive_word(4'd4);
        push_exp("clamp");
        wait_done();

        // abort with word in same RUN cycle; abort/word_valid in IDLE ignored
        do_start(16'd5);
        drive_word(4'd1);
        drive_word(4'd2);
        abort = 1'b1; word_valid = 1'b1; err_count = 4'd3;
        tick();
        abort = 1'b0; word_valid = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_words", 32'(words_seen), 32'd2);
        chk("abort_errs", 32'(total_errors), 32'd3);
        abort = 1'b1; tick(); abort = 1'b0;
        word_valid = 1'b1; err_count = 4'd5; tick(); word_valid = 1'b0;
        chk("idle_words", 32'(words_seen), 32'd2);
        chk("idle_busy", 32'(busy), 0);

        // Sync loss and recovery: set on word 8 only, 58 errors
        do_start(16'd10);
        for (int i = 0; i < 10; i++) begin
            drive_word(pat[i]);
            chk($sformatf("sync_w%0d", i + 1), 32'(sync_lost), 32'(m_sync));
        end
        chk("sync_errs_const", 32'(total_errors), 32'd58);
        push_exp("sync");
        wait_done();

        // Back-to-back: start on first DONE cycle
        window_len = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_done", 32'(done), 0);
        chk("b2b_sync", 32'(sync_lost), 0);
        chk("b2b_words", 32'(words_seen), 0);
        chk("b2b_errs", 32'(total_errors), 0);
        drive_word(4'd0);
        drive_word(4'd0);
        push_exp("b2b");
        wait_done();

        // Reset mid-window
        do_start(16'd8);
        for (int i = 0; i < 3; i++) drive_word(4'd5);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_bits", 32'(total_bits), 0);
        chk("midrst_errs", 32'(total_errors), 0);
        chk("midrst_words", 32'(words_seen), 0);
        rst = 1'b0;
        tick(); tick();
        chk("postrst_busy", 32'(busy), 0);
        do_start(16'd2);
        drive_word(4'd1);
        drive_word(4'd13);
        push_exp("afterrst");
        wait_done();

        // Maximum window: 65536 words of 13 errors
        do_start(16'd0);
        for (int i = 0; i < 65535; i++) drive_word(4'd13);
        chk("max_notdone", 32'(done), 0);
        chk("max_busy", 32'(busy), 1);
        drive_word(4'd13);
        chk("max_bits_const", 32'(total_bits), 32'd851968);
        chk("max_words_const", 32'(words_seen), 32'd65536);
        push_exp("max");
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ber_accum.md
BER_ACCUM -- requirements
Module: ber_accum

Interface
REQ-001 Parameter WORD_BITS, default 13: bits compared per word.
REQ-002 Parameter LOSS_THRESH, default 7: per-word error count at or above which a word counts as "bad".
REQ-003 Parameter LOSS_RUN, default 4: consecutive bad words that declare sync loss.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: begin a measurement window; 1-cycle pulse.
REQ-007 abort  input  1: end the current window without completing it.
REQ-008 window_len  input  16: window length in words, sampled on the accepted start; 0 means 65536.
REQ-009 word_valid  input  1: err_count carries a new word's result this cycle.
REQ-010 err_count  input  4: mismatched bits in the word from the upstream comparator; legal range 0..13.
REQ-011 busy  output  1: high in RUN.
REQ-012 done  output  1: high in DONE.
REQ-013 total_bits  output  20: bits compared in the current or last window.
REQ-014 total_errors  output  20: bit errors in the current or last window.
REQ-015 words_seen  output  17: words accepted in the current or last window.
REQ-016 sync_lost  output  1: sticky sync-loss flag.
REQ-017 err_invalid  output  1: sticky flag for an out-of-range err_count.

Function
REQ-018 The block shall implement states IDLE, RUN and DONE.
REQ-019 IDLE or DONE with start=1: clear total_bits, total_errors, words_seen, sync_lost, err_invalid and the bad-word run counter; latch window_len; next state RUN.
REQ-020 A word_valid in the same cycle as an accepted start shall not be counted.
REQ-021 RUN with word_valid=1 and abort=0: total_bits += WORD_BITS, total_errors += clamped err_count, words_seen += 1; registered outputs update the next cycle.
REQ-022 err_count > 13 shall be clamped to 13 and shall set err_invalid.
REQ-023 RUN: when the accepted word makes words_seen equal the latched length (0 treated as 65536), next state DONE.
REQ-024 RUN with abort=1: next state IDLE, with no word counted that cycle and counters holding their values.
REQ-025 abort shall have priority over word_valid and over window completion in the same cycle.
REQ-026 start during RUN shall be ignored.
REQ-027 abort in IDLE or DONE shall be ignored.
REQ-028 word_valid outside RUN shall be ignored.
REQ-029 DONE shall hold all counters and flags until the next start, which may be accepted on the first DONE cycle.
REQ-030 RUN, accepted word with clamped err_count ≥ LOSS_THRESH: increment the bad-word run counter (saturating at LOSS_RUN).
REQ-031 RUN, accepted word below LOSS_THRESH: clear the run counter.
REQ-032 The run counter reaching LOSS_RUN shall set sync_lost.
REQ-033 Sync loss shall not stop the measurement.
REQ-034 Counter widths shall be sufficient that no counter can overflow: 65536 × 13 = 851968 < 2^20.

Reset
REQ-035 rst=1 shall immediately force state IDLE.
REQ-036 rst=1 shall immediately clear busy, done, total_bits, total_errors, words_seen, sync_lost, err_invalid, the run counter and the latched window length.
REQ-037 rst asserted mid-RUN shall discard the window; after deassertion the block stays in IDLE until start.

Verification
REQ-038 Basic window: window_len=4, start, four words with err_count 0,1,2,3 -> DONE with total_bits=52, total_errors=6, words_seen=4, busy=0, done=1.
REQ-039 Sync loss and recovery: window_len=10, err_count pattern 7,8,13,0,7,7,7,9,0,0 -> sync_lost=1 set on word 8 only, total_errors=58.
REQ-040 Clamp and conflicts: err_count=15 -> counted as 13, err_invalid=1; start and word_valid in the same IDLE cycle -> words_seen=0; abort and word_valid in the same RUN cycle -> IDLE, word not counted.
REQ-041 Maximum window: window_len=0, 65536 words of err_count=13 -> DONE with words_seen=65536, total_bits=851968, total_errors=851968, no wrap.
REQ-042 Reset mid-window: rst after 3 words of window_len=8 -> all outputs 0 and state IDLE; a following start with window_len=2 completes normally.
REQ-043 Back-to-back windows: start on the first DONE cycle -> counters and flags cleared, busy=1 next cycle, prior sync_lost cleared.
